ram_arbiter: RTL

//  Shares the single-port RAMblock (10-bit address, bidirectional 8-bit data, read/write strobes)

---
 rtl/ram_arb_pkg.sv | 15 +
 rtl/rr_arbiter2.sv | 19 +
 rtl/ram_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAM arbiter: FSM state encoding and requester port indices.
package ram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    RESP = 3'd3,
    TURN = 3'd4
  } state_t;

  localparam int PORT_FETCH = 0;  // instruction fetch requester
  localparam int PORT_LSU   = 1;  // load/store unit requester

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker. On a tie the port named by ptr wins; otherwise the
// lone requester wins. Purely combinational, grant is one-hot or zero.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);

  // Tie goes to the pointer port, a single request passes straight through.
  always_comb begin
    grant = 2'b00;
    if (req == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end else begin
      grant = req;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between instruction fetch (port 0) and the load/store
// unit (port 1). One transaction in flight, round-robin on ties. Every RAM-side
// signal comes straight from a register; the data bus is driven only during writes.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int WR_HOLD = 2,
  parameter int RD_LAT  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_address,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              ram_read,
  output logic              ram_write
);

  localparam int MAX_LAT = (WR_HOLD > RD_LAT) ? WR_HOLD : RD_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                rr_reg, rr_next;
  logic                owner_reg, owner_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [DATA_W-1:0]   rdata_reg, rdata_next;
  logic [1:0]          gnt_reg, gnt_next;
  logic [1:0]          rvalid_reg, rvalid_next;
  logic                rd_reg, rd_next;
  logic                wr_reg, wr_next;
  logic [1:0]          grant;
  logic                pick;

  rr_arbiter2 u_rr (
    .req   ({req1, req0}),
    .ptr   (rr_reg),
    .grant (grant)
  );

  assign pick = grant[PORT_LSU];

  // Next-state and next-output logic; only IDLE looks at the requesters.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    rr_next     = rr_reg;
    owner_next  = owner_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    rdata_next  = rdata_reg;
    gnt_next    = 2'b00;
    rvalid_next = 2'b00;
    rd_next     = 1'b0;
    wr_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (|grant) begin
          owner_next = pick;
          addr_next  = pick ? addr1 : addr0;
          wdata_next = pick ? wdata1 : wdata0;
          rr_next    = ~pick;
          gnt_next   = grant;
          if (pick ? we1 : we0) begin
            state_next = WR;
            wr_next    = 1'b1;
            cnt_next   = CNT_W'(WR_HOLD - 1);
          end else begin
            state_next = RD;
            rd_next    = 1'b1;
            cnt_next   = CNT_W'(RD_LAT - 1);
          end
        end
      end
      WR: begin
        if (cnt_reg == '0) begin
          state_next = TURN;
        end else begin
          cnt_next = cnt_reg - 1'b1;
          wr_next  = 1'b1;
        end
      end
      RD: begin
        if (cnt_reg == '0) begin
          rdata_next  = ram_data;
          state_next  = RESP;
          rvalid_next = owner_reg ? 2'b10 : 2'b01;
        end else begin
          cnt_next = cnt_reg - 1'b1;
          rd_next  = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      TURN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction and releases the bus at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      rr_reg     <= 1'b0;
      owner_reg  <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      gnt_reg    <= 2'b00;
      rvalid_reg <= 2'b00;
      rd_reg     <= 1'b0;
      wr_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      rr_reg     <= rr_next;
      owner_reg  <= owner_next;
      addr_reg   <= addr_next;
      wdata_reg  <= wdata_next;
      rdata_reg  <= rdata_next;
      gnt_reg    <= gnt_next;
      rvalid_reg <= rvalid_next;
      rd_reg     <= rd_next;
      wr_reg     <= wr_next;
    end
  end

  assign gnt0        = gnt_reg[PORT_FETCH];
  assign gnt1        = gnt_reg[PORT_LSU];
  assign rvalid0     = rvalid_reg[PORT_FETCH];
  assign rvalid1     = rvalid_reg[PORT_LSU];
  assign rdata       = rdata_reg;
  assign busy        = (state_reg != IDLE);
  assign ram_address = addr_reg;
  assign ram_read    = rd_reg;
  assign ram_write   = wr_reg;
  assign ram_data    = wr_reg ? wdata_reg : {DATA_W{1'bz}};

endmodule
